param_sync_fifo: RTL
====================

// Module: param_sync_fifo
// PURPOSE
// - Single-clock FIFO with parametrised width, depth and read mode (standard or first-word-fall-through).
// - Provides fill count, almost-full/almost-empty thresholds, overflow/underflow error pulses and a synchronous flush.
// - Sits between same-clock producer/consumer blocks as the general buffering primitive of the design.
// PARAMETERS
// - WIDTH     16        data word width, >=1
// - DEPTH     16        number of entries; power of 2, >=2
// - AF_LEVEL  DEPTH-2   almost_full asserted when count >= AF_LEVEL
// - AE_LEVEL  2         almost_empty asserted when count <= AE_LEVEL
// - FWFT      0         0 = standard registered read; 1 = first-word-fall-through
// PORTS
// - clk           in   1               clock, all logic on rising edge
// - rst_          in   1               reset, asynchronous, active-low
// - clr           in   1               synchronous flush, active-high
// - wr_en         in   1               write request
// - wr_data       in   WIDTH           write data
// - rd_en         in   1               read request (FWFT: pop head word)
// - rd_data       out  WIDTH           read data
// - rd_valid      out  1               rd_data holds a valid word
// - full          out  1               no free entry
// - empty         out  1               no stored entry
// - almost_full   out  1               count >= AF_LEVEL
// - almost_empty  out  1               count <= AE_LEVEL
// - count         out  $clog2(DEPTH)+1 stored entries, 0..DEPTH
// - overflow      out  1               1-cycle pulse: write rejected
// - underflow     out  1               1-cycle pulse: read rejected
// BEHAVIOUR
// - Reset (rst_=0, immediate):
//   - empty=1, almost_empty=1; full=0, almost_full=0; count=0; overflow=0, underflow=0; rd_data=0, rd_valid=0.
//   - Pointers are cleared and contents are discarded. Memory is not cleared.
// - Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits and wrap naturally.
//   - empty when the pointers are equal.
//   - full when the MSBs differ and the lower bits are equal.
// - Flag timing: all flags and count are registered from next-state values. They are correct in the cycle after the edge that changed occupancy, with no extra lag.
// - Accept rules (use current-cycle flags):
//   - wr_acc = wr_en & ~full.
//   - rd_acc = rd_en & ~empty.
//   - Both accepted: count is unchanged, both pointers advance.
//   - Full with wr_en & rd_en: read accepted, write rejected; count becomes DEPTH-1 and overflow pulses.
//   - Empty with wr_en & rd_en: write accepted, read rejected; count becomes 1 and underflow pulses.
// - Errors: overflow=1 in the cycle after an edge with wr_en & full; underflow likewise for rd_en & empty. Pointers, count and memory are unchanged by a rejected request.
// - Standard mode (FWFT=0):
//   - rd_data is registered: it updates on the edge where rd_acc=1, and rd_valid=1 for exactly that following cycle.
//   - rd_data holds its value otherwise.
//   - Latency: write at edge N -> read issued in cycle N+1 -> data at edge N+2.
// - FWFT mode (FWFT=1):
//   - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
//   - A word written at edge N is visible right after edge N.
//   - rd_en with rd_valid=1 pops the head word.
// - clr: next edge resets pointers, count, flags and error pulses as reset does, and sets rd_valid=0.
//   - clr has priority over wr_en and rd_en in the same cycle.
//   - rd_data holds its value.
// - Reset mid-operation: takes effect asynchronously; a transfer in the same cycle is lost.
// STRUCTURE
// - Package fifo_pkg:
//   - function ptr_w(depth) = $clog2(depth)+1.
//   - typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e.
//   - Shared threshold-check helper.
// - Sub-module fifo_ram #(WIDTH, DEPTH): one synchronous write port and one asynchronous read port. It has no reset.
// - The top level holds pointers, count, flags, error pulses and the read-mode output stage.
// TESTING (WIDTH=16, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
// 1. Reset: assert rst_=0 mid-cycle -> empty=1, almost_empty=1, count=0, full=0, rd_valid=0 immediately.
// 2. Fill: write 0x0001..0x0010 -> almost_full=1 at count=14, full=1 at count=16. A 17th write -> overflow=1 for one cycle and count stays 16.
// 3. Drain: FWFT=0, read 16 words -> rd_data 0x0001..0x0010 in order, each with rd_valid=1, then empty=1. An extra read -> underflow=1 for one cycle.
// 4. Wrap: at count=8, assert wr_en & rd_en for 40 cycles -> count stays 8, output order is preserved across pointer wrap.
// 5. Boundaries: full + wr_en & rd_en -> count=15, overflow=1. Empty + both -> count=1, underflow=1. Asserting clr with wr_en -> count=0, empty=1.
// 6. FWFT=1: write 0xABCD into an empty FIFO -> rd_data=0xABCD and rd_valid=1 the cycle after the write. rd_en pops it -> empty=1 and rd_valid=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
// Pointer width, read-mode encoding and the threshold comparisons used by the flags.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    // One extra pointer bit separates the full and empty states when the address bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic thr_ge(input int value, input int level);
        return value >= level;
    endfunction

    function automatic logic thr_le(input int value, input int level);
        return value <= level;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds, error pulses and flush.
// Read side is either a registered output stage or first-word-fall-through.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic             wr_acc, rd_acc;
    logic             full_nxt, empty_nxt;
    logic [WIDTH-1:0] ram_rdata;

    // Flags are registered from the next-state pointers so they carry no extra lag.
    always_comb begin
        wr_acc     = wr_en & ~full;
        rd_acc     = rd_en & ~empty;
        wr_ptr_nxt = wr_ptr + PW'(wr_acc);
        rd_ptr_nxt = rd_ptr + PW'(rd_acc);
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= full_nxt;
            empty        <= empty_nxt;
            almost_full  <= thr_ge(int'(count_nxt), AF_LEVEL);
            almost_empty <= thr_le(int'(count_nxt), AE_LEVEL);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~clr),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
            // Head word is presented directly; masked while empty so stale memory never shows.
            assign rd_data  = empty ? '0 : ram_rdata;
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (clr) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= ram_rdata;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule
